// File: rtl/log_capture_mem_if.sv
// Bundle between the GPIO register block / datapath and the log capture buffer.
// master: the GPIO block and datapath side; slave: log_capture_mem.
interface log_capture_mem_if #(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned ADDR_LEN = 15
);

    // Datapath samples
    logic [DATA_LEN-1:0] data_in;
    logic                data_valid;

    // Control from the GPIO register block
    logic                run;
    logic                trigger;
    logic                read_enable;
    logic [ADDR_LEN-1:0] read_address;

    // Status and readback returned to the GPIO register block
    logic [DATA_LEN-1:0] mem_data;
    logic                mem_full;
    logic                logging;

    modport master (
        output data_in,
        output data_valid,
        output run,
        output trigger,
        output read_enable,
        output read_address,
        input  mem_data,
        input  mem_full,
        input  logging
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  run,
        input  trigger,
        input  read_enable,
        input  read_address,
        output mem_data,
        output mem_full,
        output logging
    );

endinterface

// File: rtl/log_capture_mem.sv
// Log capture buffer. A rising edge on run starts a capture of consecutive
// valid datapath words into an internal RAM until it is full; the buffer is
// then read back word by word with a one-cycle registered latency.
// Optional build macro LOG_CAPTURE_TRIGGER_EN: after the run edge the capture
// waits in an armed state until the trigger input goes high.
module log_capture_mem #(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned ADDR_LEN = 15
) (
    input logic              clk,
    input logic              rst,
    log_capture_mem_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_LEN;

    // Terminal write address; full is detected here rather than by overflow.
    localparam logic [ADDR_LEN:0] LAST_PTR = {1'b0, {ADDR_LEN{1'b1}}};

`ifdef LOG_CAPTURE_TRIGGER_EN
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StFull    = 2'd2,
        StArmed   = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StFull    = 2'd2
    } state_e;
`endif

    state_e              state_q, state_d;
    logic [ADDR_LEN:0]   wptr_q, wptr_d;
    logic                mem_full_q, mem_full_d;
    logic                logging_q, logging_d;
    logic                run_q;
    logic                start;
    logic                wr_en;
    logic                rd_en;
    logic [DATA_LEN-1:0] mem_data_q;

    logic [DATA_LEN-1:0] ram [DEPTH];

`ifndef LOG_CAPTURE_TRIGGER_EN
    // The trigger port is kept for a uniform interface but has no effect here.
    logic unused_trigger;
    assign unused_trigger = bus.trigger;
`endif

    assign start = bus.run & ~run_q;

    // Reads are only honoured once capture has stopped, so the RAM never sees
    // a read and a write in the same cycle.
    assign rd_en = bus.read_enable & ~logging_q;

    // Next-state, pointer and status decode.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        mem_full_d = mem_full_q;
        logging_d  = logging_q;
        wr_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A sample coinciding with the start edge is not captured.
                if (start) begin
                    wptr_d     = '0;
                    mem_full_d = 1'b0;
                    logging_d  = 1'b1;
`ifdef LOG_CAPTURE_TRIGGER_EN
                    state_d    = StArmed;
`else
                    state_d    = StCapture;
`endif
                end
            end

`ifdef LOG_CAPTURE_TRIGGER_EN
            StArmed: begin
                if (!bus.run) begin
                    state_d   = StIdle;
                    logging_d = 1'b0;
                end else if (bus.trigger) begin
                    state_d = StCapture;
                    // A sample in the trigger cycle lands at address 0.
                    if (bus.data_valid) begin
                        wr_en  = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end
`endif

            StCapture: begin
                // The sample in an abort cycle is still written.
                if (bus.data_valid) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                end
                // Completing the last word wins over a simultaneous abort.
                if (bus.data_valid && (wptr_q == LAST_PTR)) begin
                    state_d    = StFull;
                    mem_full_d = 1'b1;
                    logging_d  = 1'b0;
                end else if (!bus.run) begin
                    state_d   = StIdle;
                    logging_d = 1'b0;
                end
            end

            StFull: begin
                // mem_full stays set until the next start.
                if (!bus.run) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d   = StIdle;
                logging_d = 1'b0;
            end
        endcase
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            mem_full_q <= 1'b0;
            logging_q  <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            mem_full_q <= mem_full_d;
            logging_q  <= logging_d;
            run_q      <= bus.run;
        end
    end

    // Capture RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wptr_q[ADDR_LEN-1:0]] <= bus.data_in;
        end
    end

    // Registered readback; holds its value when no read is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_data_q <= '0;
        end else if (rd_en) begin
            mem_data_q <= ram[bus.read_address];
        end
    end

    assign bus.mem_data = mem_data_q;
    assign bus.mem_full = mem_full_q;
    assign bus.logging  = logging_q;

endmodule

// File: tb/tb_log_capture_mem.sv
// Directed bench for log_capture_mem with a 16-word buffer. Readback
// expectations are queued when a read is issued and popped one cycle later.
module tb_log_capture_mem;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    log_capture_mem_if #(.DATA_LEN(DW), .ADDR_LEN(AW)) bus ();

    log_capture_mem #(.DATA_LEN(DW), .ADDR_LEN(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] observed,
                         input logic [DW-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issue one read and compare the registered word on the next cycle.
    task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] expected,
                      input string tag);
        logic [DW-1:0] want;
        bus.read_enable  = 1'b1;
        bus.read_address = addr;
        exp_q.push_back(expected);
        tick();
        want = exp_q.pop_front();
        check(tag, bus.mem_data, want);
        bus.read_enable = 1'b0;
    endtask

    initial begin
        bus.data_in      = '0;
        bus.data_valid   = 1'b0;
        bus.run          = 1'b0;
        bus.read_enable  = 1'b0;
        bus.read_address = '0;
        // Held high so the armed state (when built in) passes straight through.
        bus.trigger      = 1'b1;

        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("reset_mem_full", bus.mem_full, 0);
        check("reset_logging", bus.logging, 0);
        check("reset_mem_data", bus.mem_data, 0);

        // Reset in the middle of a capture
        bus.run = 1'b1;
        tick();
        check("start_logging", bus.logging, 1);
        for (int i = 0; i < 5; i++) begin
            bus.data_in    = 32'h200 + i;
            bus.data_valid = 1'b1;
            tick();
        end
        bus.data_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("async_rst_logging", bus.logging, 0);
        check("async_rst_mem_full", bus.mem_full, 0);
        bus.run = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        check("post_rst_logging", bus.logging, 0);
        check("post_rst_mem_full", bus.mem_full, 0);
        check("post_rst_mem_data", bus.mem_data, 0);
        rd(0, 32'h200, "rd_ram_kept_over_rst");

        // Fill the buffer with spaced samples
        bus.run = 1'b1;
        tick();
        check("fill_logging", bus.logging, 1);
        for (int i = 0; i < 16; i++) begin
            bus.data_in    = 32'h100 + i;
            bus.data_valid = 1'b1;
            tick();
            bus.data_valid = 1'b0;
            if (i == 14) check("full_before_last", bus.mem_full, 0);
            if (i == 15) begin
                check("full_after_last", bus.mem_full, 1);
                check("logging_after_full", bus.logging, 0);
            end
            repeat (2) tick();
        end
        bus.run = 1'b0;
        tick();
        check("full_held_in_idle", bus.mem_full, 1);
        for (int i = 0; i < 16; i++) begin
            rd(AW'(i), 32'h100 + i, "rd_fill");
        end

        // Continuous samples beyond the depth
        bus.run = 1'b1;
        tick();
        check("rerun_clears_full", bus.mem_full, 0);
        for (int i = 0; i < 20; i++) begin
            bus.data_in    = 32'h500 + i;
            bus.data_valid = 1'b1;
            tick();
        end
        bus.data_valid = 1'b0;
        check("overflow_full", bus.mem_full, 1);
        check("overflow_logging", bus.logging, 0);
        bus.run = 1'b0;
        tick();
        rd(0, 32'h500, "rd_overflow_addr0");
        rd(5, 32'h505, "rd_overflow_addr5");
        rd(15, 32'h50F, "rd_overflow_addr15");

        // Abort after seven words; the seventh coincides with run falling
        bus.run = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            bus.data_in    = 32'h600 + i;
            bus.data_valid = 1'b1;
            if (i == 6) bus.run = 1'b0;
            tick();
        end
        bus.data_valid = 1'b0;
        check("abort_logging", bus.logging, 0);
        check("abort_mem_full", bus.mem_full, 0);
        tick();
        check("abort_stays_idle", bus.logging, 0);
        rd(6, 32'h606, "rd_abort_last_word");
        rd(7, 32'h507, "rd_abort_stale");

        // Reads are ignored while logging
        bus.run = 1'b1;
        tick();
        check("relog_logging", bus.logging, 1);
        rd(3, 32'h507, "rd_blocked_logging");
        bus.run = 1'b0;
        tick();
        check("relog_abort_logging", bus.logging, 0);
        rd(3, 32'h603, "rd_after_relog");

        // Sample on the start cycle is dropped; next sample goes to address 0
        bus.data_in    = 32'h777;
        bus.data_valid = 1'b1;
        bus.run        = 1'b1;
        tick();
        bus.data_in = 32'h700;
        tick();
        bus.data_valid = 1'b0;
        bus.run        = 1'b0;
        tick();
        rd(0, 32'h700, "rd_first_after_start");
        rd(1, 32'h601, "rd_untouched_addr1");

`ifdef LOG_CAPTURE_TRIGGER_EN
        // Armed without trigger: no writes until trigger rises
        bus.trigger = 1'b0;
        bus.run     = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.data_in    = 32'h800 + i;
            bus.data_valid = 1'b1;
            tick();
        end
        bus.data_valid = 1'b0;
        check("armed_logging", bus.logging, 1);
        rd(2, 32'h601, "rd_blocked_armed");
        bus.trigger    = 1'b1;
        bus.data_in    = 32'hAA;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        bus.run        = 1'b0;
        tick();
        check("trigger_abort_logging", bus.logging, 0);
        rd(0, 32'hAA, "rd_trigger_word");
        rd(1, 32'h601, "rd_trigger_addr1");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/log_capture_mem.md
Name: log_capture_mem

Overview:
- Capture buffer sitting downstream of the GPIO register block.
- Driven by that block's run_log_reg, read_enable_reg and read_address_reg outputs; returns mem_full and mem_data to it.
- On a run request, records consecutive valid datapath words into an internal single-port-style RAM until full.
- The MicroBlaze then reads the buffer back word by word over GPIO.

Parameters:
- DATA_LEN, 32, width of a captured word (matches GPIO width).
- ADDR_LEN, 15, address width; depth = 2**ADDR_LEN words.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset (one clock domain, clk).
- data_in  in  DATA_LEN  datapath word to log.
- data_valid  in  1  data_in qualifier, one-cycle strobe per sample.
- run  in  1  capture request level (from run_log_reg).
- read_enable  in  1  readback enable (from read_enable_reg).
- read_address  in  ADDR_LEN  readback address (from read_address_reg).
- trigger  in  1  capture start qualifier; used only with LOG_CAPTURE_TRIGGER_EN, ignored otherwise.
- mem_data  out  DATA_LEN  registered readback word.
- mem_full  out  1  buffer completely written since last run start.
- logging  out  1  capture in progress.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; write pointer=0; mem_full=0; logging=0; mem_data=0; run edge detector=0.
  - RAM contents are not cleared.
- Run edge: run_d is run delayed one cycle; start = run & ~run_d.
- States: IDLE, CAPTURE, FULL (plus ARMED with the optional feature).
- IDLE:
  - On start: wptr<=0, mem_full<=0, logging<=1, go to CAPTURE.
  - A run level already high with no rising edge does nothing.
- CAPTURE:
  - Each cycle with data_valid=1: RAM[wptr]<=data_in, wptr<=wptr+1.
  - When the write at wptr=2**ADDR_LEN-1 occurs: mem_full<=1 and logging<=0 on the next edge, go to FULL. The pointer is not wrapped and further writes are blocked.
  - run=0 (abort): go to IDLE on the next edge, logging<=0, mem_full stays 0. Words already written are kept; data_valid in the abort cycle is still written.
- FULL:
  - Holds mem_full=1 and ignores data_valid.
  - run=0 moves to IDLE; mem_full stays 1 until the next start.
- Readback:
  - Each cycle with read_enable=1 and logging=0: mem_data<=RAM[read_address] (1-cycle latency).
  - Otherwise mem_data holds its value.
  - Reads while logging=1 are ignored and mem_data is held.
- Simultaneous start and data_valid in IDLE: that sample is not captured; the first capture is the next valid cycle in CAPTURE.
- New start while in FULL: impossible without run first falling; run must drop and rise again.
- Reset mid-capture: immediate return to IDLE; mem_full=0.
- Address arithmetic: ADDR_LEN+1-bit pointer; full detected by the terminal address, not by overflow.

Optional Feature:
- Macro LOG_CAPTURE_TRIGGER_EN.
- Defined:
  - start goes to ARMED (logging=1, no writes).
  - ARMED goes to CAPTURE in the first cycle with trigger=1; a data_valid in that same cycle is written to address 0.
  - run=0 in ARMED returns to IDLE.
- Undefined: no ARMED state; start goes straight to CAPTURE; the trigger port exists but is unused.

Test Plan (ADDR_LEN=4, depth 16):
- Reset mid-capture after 5 words, release, no run edge -> mem_full=0, logging=0, state IDLE, mem_data=0.
- run 0->1, then 16 data_valid pulses with data_in=0x100+i (two idle cycles between each) -> mem_full=1 the cycle after the 16th write. Then run=0, read_enable=1, read_address=0..15 -> mem_data=0x100..0x10F, each one cycle after the address is applied.
- Continuous data_valid for 20 cycles after start -> only 0x100..0x10F stored; address 0 not overwritten; mem_full=1.
- Abort: run=0 after 7 writes -> logging=0, mem_full=0; read address 6 returns the 7th word, address 7 returns the stale previous value.
- Read attempt with read_enable=1 during capture, address 3 -> mem_data unchanged. Re-run with a fresh rising edge -> mem_full drops to 0 on the start cycle.
- With LOG_CAPTURE_TRIGGER_EN: start, data_valid for 10 cycles with trigger=0 -> no writes, logging=1. trigger=1 together with data_in=0xAA -> 0xAA at address 0.
